// File: rtl/pong_render.sv
// Pong video back end: 640x480@60 VGA timing, once-per-frame sprite coordinate capture, 12-bit RGB renderer.
// Optional dashed centre net is compiled in when PONG_NET_EN is defined.
module pong_render #(
    parameter int H_VIDEO    = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIDEO    = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SQ_WIDTH   = 16,
    parameter int PDL_WIDTH  = 12,
    parameter int PDL_HEIGHT = 96
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] sq_xpos,
    input  logic [9:0] sq_ypos,
    input  logic [9:0] pdl1_xpos,
    input  logic [9:0] pdl1_ypos,
    input  logic [9:0] pdl2_xpos,
    input  logic [9:0] pdl2_ypos,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick
);
    localparam logic [9:0]  H_LAST = 10'(H_VIDEO + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST = 10'(V_VIDEO + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_ACT  = 10'(H_VIDEO);
    localparam logic [9:0]  V_ACT  = 10'(V_VIDEO);
    localparam logic [9:0]  H_SS   = 10'(H_VIDEO + H_FP);
    localparam logic [9:0]  H_SE   = 10'(H_VIDEO + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_SS   = 10'(V_VIDEO + V_FP);
    localparam logic [9:0]  V_SE   = 10'(V_VIDEO + V_FP + V_SYNC - 1);
    localparam logic [10:0] SQ_W   = 11'(SQ_WIDTH);
    localparam logic [10:0] PDL_W  = 11'(PDL_WIDTH);
    localparam logic [10:0] PDL_H  = 11'(PDL_HEIGHT);
`ifdef PONG_NET_EN
    localparam logic [9:0]  NET_L  = 10'(H_VIDEO / 2 - 2);
    localparam logic [9:0]  NET_R  = 11'(H_VIDEO / 2 + 1) > 11'd1023 ? 10'd1023 : 10'(H_VIDEO / 2 + 1);
`endif

    // Ends are summed 11 bits wide so a sprite near the right/bottom edge clips instead of wrapping to 0.
    function automatic logic obj_hit(input logic [9:0] h, input logic [9:0] v,
                                     input logic [9:0] x, input logic [9:0] y,
                                     input logic [10:0] w, input logic [10:0] ht);
        logic [10:0] x_end;
        logic [10:0] y_end;
        x_end = {1'b0, x} + w;
        y_end = {1'b0, y} + ht;
        return (h >= x) && ({1'b0, h} < x_end) && (v >= y) && ({1'b0, v} < y_end);
    endfunction

    logic [9:0]  r_hcount, r_vcount;
    logic [9:0]  w_hcount_nx, w_vcount_nx;
    logic        w_latch;
    logic        r_frame_tick;
    logic [9:0]  r_sq_x, r_sq_y, r_p1_x, r_p1_y, r_p2_x, r_p2_y;
    logic        r_active, r_sq_hit, r_p1_hit, r_p2_hit, r_net_hit, r_hs_term, r_vs_term;
    logic        w_net_hit;
    logic [11:0] w_rgb, r_rgb;
    logic        r_hsync, r_vsync;

    // Next counter position; also used to pre-register frame_tick so it lines up with the counter.
    always_comb begin
        w_hcount_nx = r_hcount + 10'd1;
        w_vcount_nx = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nx = 10'd0;
            if (r_vcount == V_LAST) begin
                w_vcount_nx = 10'd0;
            end else begin
                w_vcount_nx = r_vcount + 10'd1;
            end
        end else begin
            w_vcount_nx = r_vcount;
        end
        w_latch = (r_hcount == 10'd0) && (r_vcount == V_ACT);
    end

    // Stage 0: pixel/line counters and the start-of-blanking tick.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_hcount     <= 10'd0;
            r_vcount     <= 10'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_hcount     <= w_hcount_nx;
            r_vcount     <= w_vcount_nx;
            r_frame_tick <= (w_hcount_nx == 10'd0) && (w_vcount_nx == V_ACT);
        end
    end

    // Shadow coordinates change only at the start of vertical blanking, so no frame is ever torn.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_sq_x <= 10'd320;
            r_sq_y <= 10'd240;
            r_p1_x <= 10'd24;
            r_p1_y <= 10'd191;
            r_p2_x <= 10'd603;
            r_p2_y <= 10'd191;
        end else if (w_latch) begin
            r_sq_x <= sq_xpos;
            r_sq_y <= sq_ypos;
            r_p1_x <= pdl1_xpos;
            r_p1_y <= pdl1_ypos;
            r_p2_x <= pdl2_xpos;
            r_p2_y <= pdl2_ypos;
        end else begin
            r_sq_x <= r_sq_x;
            r_sq_y <= r_sq_y;
            r_p1_x <= r_p1_x;
            r_p1_y <= r_p1_y;
            r_p2_x <= r_p2_x;
            r_p2_y <= r_p2_y;
        end
    end

    // Dashed net: 4 columns around the centre, 16 lines on / 16 off.
    always_comb begin
`ifdef PONG_NET_EN
        w_net_hit = (r_hcount >= NET_L) && (r_hcount <= NET_R) && (r_vcount[4] == 1'b0);
`else
        w_net_hit = 1'b0;
`endif
    end

    // Stage 1: visibility, object hits and raw sync terms.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_active  <= 1'b0;
            r_sq_hit  <= 1'b0;
            r_p1_hit  <= 1'b0;
            r_p2_hit  <= 1'b0;
            r_net_hit <= 1'b0;
            r_hs_term <= 1'b1;
            r_vs_term <= 1'b1;
        end else begin
            r_active  <= (r_hcount < H_ACT) && (r_vcount < V_ACT);
            r_sq_hit  <= obj_hit(r_hcount, r_vcount, r_sq_x, r_sq_y, SQ_W, SQ_W);
            r_p1_hit  <= obj_hit(r_hcount, r_vcount, r_p1_x, r_p1_y, PDL_W, PDL_H);
            r_p2_hit  <= obj_hit(r_hcount, r_vcount, r_p2_x, r_p2_y, PDL_W, PDL_H);
            r_net_hit <= w_net_hit;
            r_hs_term <= !((r_hcount >= H_SS) && (r_hcount <= H_SE));
            r_vs_term <= !((r_vcount >= V_SS) && (r_vcount <= V_SE));
        end
    end

    // Colour priority: blanking, then sprites, then net, then background.
    always_comb begin
        w_rgb = 12'h000;
        if (!r_active) begin
            w_rgb = 12'h000;
        end else if (r_sq_hit || r_p1_hit || r_p2_hit) begin
            w_rgb = 12'hFFF;
        end else if (r_net_hit) begin
            w_rgb = 12'h888;
        end else begin
            w_rgb = 12'h000;
        end
    end

    // Stage 2: registered pins, syncs delayed alongside the colour.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb;
            r_hsync <= r_hs_term;
            r_vsync <= r_vs_term;
        end
    end

    assign red        = r_rgb[11:8];
    assign green      = r_rgb[7:4];
    assign blue       = r_rgb[3:0];
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_frame_tick;
endmodule
